reg_writeback: RTL and testbench



---
 rtl/reg_writeback.sv | 167 ++++++++++++++++
 tb/tb_reg_writeback.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// reg_writeback
// Write-side controller for the 8x16 register file. Merges single-cycle ALU
// results and multi-cycle LSU results onto the file's single write port and
// keeps a per-register pending scoreboard for outstanding multi-cycle ops.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   issue_valid/issue_reg        multi-cycle op issue; issue_ready back-pressure
//   alu_valid/alu_reg/alu_data   ALU result, always accepted
//   lsu_valid/lsu_reg/lsu_data   LSU result; lsu_ready back-pressure
//   write_reg/write_data/write_en registered register-file write port
//   rd_addr1/rd_addr2            decode read addresses
//   hazard1/hazard2              pending flag of the addressed registers
//   pending                      scoreboard bitmask (bit 0 always 0)
//   lsu_orphan                   sticky: LSU wrote a register nobody was waiting on
module reg_writeback #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_reg,
  output logic              issue_ready,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_reg,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              write_en,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              hazard1,
  output logic              hazard2,
  output logic [NREG-1:0]   pending,
  output logic              lsu_orphan
);

  // State
  logic [NREG-1:0]   pending_r;
  logic              buf_full_r;
  logic [ADDR_W-1:0] buf_reg_r;
  logic [DATA_W-1:0] buf_data_r;
  logic              write_en_r;
  logic [ADDR_W-1:0] write_reg_r;
  logic [DATA_W-1:0] write_data_r;
  logic              src_lsu_r;   // current output word came from the LSU path
  logic              orphan_r;

  // Combinational
  logic              lsu_acc_s;
  logic              issue_acc_s;
  logic              sel_valid_s;
  logic              sel_lsu_s;
  logic [ADDR_W-1:0] sel_reg_s;
  logic [DATA_W-1:0] sel_data_s;
  logic              buf_load_s;
  logic              buf_drain_s;
  logic [NREG-1:0]   set_mask_s;
  logic [NREG-1:0]   clr_mask_s;
  logic [NREG-1:0]   pending_nxt_s;
  logic              orphan_set_s;

  assign lsu_ready   = ~rst & ~buf_full_r;
  assign issue_ready = ~rst & ~pending_r[issue_reg];
  assign lsu_acc_s   = lsu_valid & lsu_ready;
  assign issue_acc_s = issue_valid & issue_ready;

  assign hazard1    = pending_r[rd_addr1];
  assign hazard2    = pending_r[rd_addr2];
  assign pending    = pending_r;
  assign lsu_orphan = orphan_r;
  assign write_en   = write_en_r;
  assign write_reg  = write_reg_r;
  assign write_data = write_data_r;

  // Output source selection: ALU > holding buffer > fresh LSU beat
  always_comb begin
    sel_valid_s = 1'b0;
    sel_lsu_s   = 1'b0;
    sel_reg_s   = {ADDR_W{1'b0}};
    sel_data_s  = {DATA_W{1'b0}};
    buf_load_s  = 1'b0;
    buf_drain_s = 1'b0;
    if (alu_valid) begin
      sel_valid_s = 1'b1;
      sel_reg_s   = alu_reg;
      sel_data_s  = alu_data;
      // a beat accepted under an ALU write has to wait in the buffer
      buf_load_s  = lsu_acc_s;
    end else if (buf_full_r) begin
      sel_valid_s = 1'b1;
      sel_lsu_s   = 1'b1;
      sel_reg_s   = buf_reg_r;
      sel_data_s  = buf_data_r;
      buf_drain_s = 1'b1;
    end else if (lsu_acc_s) begin
      sel_valid_s = 1'b1;
      sel_lsu_s   = 1'b1;
      sel_reg_s   = lsu_reg;
      sel_data_s  = lsu_data;
    end else begin
      sel_valid_s = 1'b0;
    end
  end

  // Scoreboard next state: clear on the LSU write being presented, set on issue
  always_comb begin
    set_mask_s   = {NREG{1'b0}};
    clr_mask_s   = {NREG{1'b0}};
    orphan_set_s = 1'b0;
    if (issue_acc_s && (issue_reg != {ADDR_W{1'b0}})) begin
      set_mask_s[issue_reg] = 1'b1;
    end else begin
      set_mask_s = {NREG{1'b0}};
    end
    if (write_en_r && src_lsu_r) begin
      clr_mask_s[write_reg_r] = 1'b1;
      // nobody was waiting for this register
      orphan_set_s = ~pending_r[write_reg_r];
    end else begin
      clr_mask_s = {NREG{1'b0}};
    end
    // set after clear: an issue accepted while a stray LSU write to the same
    // register leaves is a new outstanding op and must stay pending
    pending_nxt_s = ((pending_r & ~clr_mask_s) | set_mask_s)
                    & ~{{(NREG-1){1'b0}}, 1'b1};
  end

  // Output register, holding buffer, scoreboard and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      write_en_r   <= 1'b0;
      write_reg_r  <= {ADDR_W{1'b0}};
      write_data_r <= {DATA_W{1'b0}};
      src_lsu_r    <= 1'b0;
      buf_full_r   <= 1'b0;
      buf_reg_r    <= {ADDR_W{1'b0}};
      buf_data_r   <= {DATA_W{1'b0}};
      pending_r    <= {NREG{1'b0}};
      orphan_r     <= 1'b0;
    end else begin
      // register 0 is consumed but never written
      write_en_r   <= sel_valid_s & (sel_reg_s != {ADDR_W{1'b0}});
      write_reg_r  <= sel_reg_s;
      write_data_r <= sel_data_s;
      src_lsu_r    <= sel_lsu_s;
      if (buf_load_s) begin
        buf_full_r <= 1'b1;
        buf_reg_r  <= lsu_reg;
        buf_data_r <= lsu_data;
      end else if (buf_drain_s) begin
        buf_full_r <= 1'b0;
      end else begin
        buf_full_r <= buf_full_r;
      end
      pending_r <= pending_nxt_s;
      orphan_r  <= orphan_r | orphan_set_s;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback. A transaction-level reference model
// (an LSU waiting queue, a pending bit array and an orphan flag) predicts each
// cycle's register-file write; expected writes go into a scoreboard queue that
// a separate negedge monitor pops whenever the DUT presents write_en.
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [2:0]  issue_reg;
  logic        issue_ready;
  logic        alu_valid;
  logic [2:0]  alu_reg;
  logic [15:0] alu_data;
  logic        lsu_valid;
  logic [2:0]  lsu_reg;
  logic [15:0] lsu_data;
  logic        lsu_ready;
  logic [2:0]  write_reg;
  logic [15:0] write_data;
  logic        write_en;
  logic [2:0]  rd_addr1;
  logic [2:0]  rd_addr2;
  logic        hazard1;
  logic        hazard2;
  logic [7:0]  pending;
  logic        lsu_orphan;

  reg_writeback dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_reg(issue_reg), .issue_ready(issue_ready),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_reg(lsu_reg), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .write_reg(write_reg), .write_data(write_data), .write_en(write_en),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .hazard1(hazard1), .hazard2(hazard2),
    .pending(pending), .lsu_orphan(lsu_orphan)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [2:0]  r;
    logic [15:0] d;
  } wr_t;

  wr_t  exp_q[$];   // scoreboard of expected register-file writes
  wr_t  lsu_q[$];   // model: LSU beats accepted but not yet written
  bit [7:0] m_pend;
  bit       m_orphan;
  bit       prev_lsu;
  bit [2:0] prev_reg;
  int       cyc;
  bit       started;
  int       n_checks;
  int       n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive, check combinational outputs, advance the model.
  task automatic step(input bit r, input bit iv, input bit [2:0] ir,
                      input bit av, input bit [2:0] ar, input bit [15:0] ad,
                      input bit lv, input bit [2:0] lr, input bit [15:0] ld,
                      input bit [2:0] ra1, input bit [2:0] ra2);
    bit  lsu_acc;
    bit  iss_acc;
    bit  this_lsu;
    bit  [2:0] this_reg;
    wr_t w;
    rst = r; issue_valid = iv; issue_reg = ir;
    alu_valid = av; alu_reg = ar; alu_data = ad;
    lsu_valid = lv; lsu_reg = lr; lsu_data = ld;
    rd_addr1 = ra1; rd_addr2 = ra2;
    #1;
    chk("lsu_ready",   lsu_ready,   !r && lsu_q.size() == 0);
    chk("issue_ready", issue_ready, !r && !m_pend[ir]);
    chk("hazard1",     hazard1,     m_pend[ra1]);
    chk("hazard2",     hazard2,     m_pend[ra2]);
    chk("pending",     pending,     m_pend);
    chk("lsu_orphan",  lsu_orphan,  m_orphan);
    if (r) begin
      lsu_q.delete();
      m_pend = 8'h00; m_orphan = 1'b0; prev_lsu = 1'b0; prev_reg = 3'd0;
    end else begin
      lsu_acc  = lv && (lsu_q.size() == 0);
      iss_acc  = iv && !m_pend[ir];
      this_lsu = 1'b0; this_reg = 3'd0;
      if (lsu_acc) begin
        w.cyc = 0; w.r = lr; w.d = ld;
        lsu_q.push_back(w);
      end
      if (av) begin
        if (ar != 3'd0) begin
          w.cyc = cyc + 1; w.r = ar; w.d = ad;
          exp_q.push_back(w);
        end
      end else if (lsu_q.size() > 0) begin
        w = lsu_q.pop_front();
        if (w.r != 3'd0) begin
          w.cyc = cyc + 1;
          exp_q.push_back(w);
          this_lsu = 1'b1; this_reg = w.r;
        end
      end
      // the LSU write presented this cycle commits now and retires its register
      if (prev_lsu) begin
        if (!m_pend[prev_reg]) m_orphan = 1'b1;
        m_pend[prev_reg] = 1'b0;
      end
      if (iss_acc && ir != 3'd0) m_pend[ir] = 1'b1;
      prev_lsu = this_lsu; prev_reg = this_reg;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input bit [2:0] ra1);
    step(0, 0, 0, 0, 0, 16'h0, 0, 0, 16'h0, ra1, 3'd0);
  endtask

  // Scoreboard monitor: compare every presented write with the model's prediction
  always @(negedge clk) begin
    wr_t e;
    if (started) begin
      if (write_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL write_unexpected: got reg %0d data %0h expected no write (cycle %0d)",
                   write_reg, write_data, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("write_cycle", cyc, e.cyc);
          chk("write_reg", write_reg, e.r);
          chk("write_data", write_data, e.d);
        end
      end else begin
        chk("write_en_known", write_en, 1'b0);
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          e = exp_q.pop_front();
          n_checks++; n_fail++;
          $display("FAIL write_missing: got write_en 0 expected reg %0d data %0h (cycle %0d)",
                   e.r, e.d, cyc);
        end
      end
    end
  end

  initial begin
    bit [2:0] lr;
    n_checks = 0; n_fail = 0; cyc = 0; started = 1'b0;
    m_pend = 8'h00; m_orphan = 1'b0; prev_lsu = 1'b0; prev_reg = 3'd0;
    rst = 1'b1; issue_valid = 1'b0; issue_reg = 3'd0;
    alu_valid = 1'b0; alu_reg = 3'd0; alu_data = 16'h0;
    lsu_valid = 1'b0; lsu_reg = 3'd0; lsu_data = 16'h0;
    rd_addr1 = 3'd0; rd_addr2 = 3'd0;
    @(posedge clk); @(posedge clk); #1;
    started = 1'b1;

    // ALU only
    step(0, 0, 0, 1, 3'd3, 16'h1234, 0, 0, 16'h0, 3'd3, 3'd0);
    idle(3'd3);

    // issue reg 5, LSU result four cycles later
    step(0, 1, 3'd5, 0, 0, 16'h0, 0, 0, 16'h0, 3'd5, 3'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 3'd5, 0, 0, 16'h0, 0, 0, 16'h0, 3'd5, 3'd5);
    step(0, 0, 3'd5, 0, 0, 16'h0, 1, 3'd5, 16'hBEEF, 3'd5, 3'd0);
    step(0, 0, 3'd5, 0, 0, 16'h0, 0, 0, 16'h0, 3'd5, 3'd0);
    idle(3'd5);

    // ALU/LSU conflict with ALU held three cycles
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 3'd2, 16'h0001, 1, 3'd4, 16'h0002, 3'd0, 3'd0);
    idle(3'd0); idle(3'd0);

    // register 0 from both directions
    step(0, 0, 0, 1, 3'd0, 16'hDEAD, 0, 0, 16'h0, 3'd0, 3'd0);
    step(0, 1, 3'd0, 0, 0, 16'h0, 0, 0, 16'h0, 3'd0, 3'd0);
    step(0, 0, 0, 0, 0, 16'h0, 1, 3'd0, 16'h5555, 3'd0, 3'd0);
    idle(3'd0);

    // orphan after a clean reset
    step(1, 0, 0, 0, 0, 16'h0, 0, 0, 16'h0, 3'd0, 3'd0);
    step(0, 0, 0, 0, 0, 16'h0, 1, 3'd6, 16'hCAFE, 3'd6, 3'd0);
    idle(3'd6); idle(3'd6); idle(3'd6);

    // reset mid-operation: buffer full, pending = 0x0C
    step(0, 1, 3'd2, 0, 0, 16'h0, 0, 0, 16'h0, 3'd2, 3'd3);
    step(0, 1, 3'd3, 0, 0, 16'h0, 0, 0, 16'h0, 3'd2, 3'd3);
    step(0, 0, 0, 1, 3'd1, 16'h1111, 1, 3'd7, 16'h7777, 3'd2, 3'd3);
    step(1, 0, 0, 1, 3'd1, 16'h2222, 0, 0, 16'h0, 3'd2, 3'd3);
    idle(3'd2); idle(3'd3);

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      lr = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        for (int k = 0; k < 8; k++) begin
          if (m_pend[3'(lr + k)]) begin
            lr = 3'(lr + k);
            break;
          end
        end
      end
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)), 16'($urandom),
           ($urandom_range(0, 2) != 0), lr, 16'($urandom),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    for (int i = 0; i < 5; i++) idle(3'd0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
